// File: rtl/rotor_b_path.sv
// Return path of the Enigma datapath: inverse rotor2, rotor1, rotor0 in a
// three-stage valid/ready pipeline; rotor positions travel with each character.
module rotor_b_path (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] data_in,
  input  logic [4:0] r1_pos,
  input  logic [4:0] r2_pos,
  input  logic [4:0] r3_pos,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] data_out,
  output logic       err
);

  // Inverse of rotor I "EKMFLGDQVZNTOWYHXUSPAIBRCJ"
  function automatic logic [4:0] inv_r0(input logic [4:0] idx);
    logic [4:0] t;
    t = 5'd0;
    case (idx)
      5'd0:  t = 5'd20;
      5'd1:  t = 5'd22;
      5'd2:  t = 5'd24;
      5'd3:  t = 5'd6;
      5'd4:  t = 5'd0;
      5'd5:  t = 5'd3;
      5'd6:  t = 5'd5;
      5'd7:  t = 5'd15;
      5'd8:  t = 5'd21;
      5'd9:  t = 5'd25;
      5'd10: t = 5'd1;
      5'd11: t = 5'd4;
      5'd12: t = 5'd2;
      5'd13: t = 5'd10;
      5'd14: t = 5'd12;
      5'd15: t = 5'd19;
      5'd16: t = 5'd7;
      5'd17: t = 5'd23;
      5'd18: t = 5'd18;
      5'd19: t = 5'd11;
      5'd20: t = 5'd17;
      5'd21: t = 5'd8;
      5'd22: t = 5'd13;
      5'd23: t = 5'd16;
      5'd24: t = 5'd14;
      5'd25: t = 5'd9;
      default: t = 5'd0;
    endcase
    return t;
  endfunction

  // Inverse of rotor II "AJDKSIRUXBLHWTMCQGZNPYFVOE"
  function automatic logic [4:0] inv_r1(input logic [4:0] idx);
    logic [4:0] t;
    t = 5'd0;
    case (idx)
      5'd0:  t = 5'd0;
      5'd1:  t = 5'd9;
      5'd2:  t = 5'd15;
      5'd3:  t = 5'd2;
      5'd4:  t = 5'd25;
      5'd5:  t = 5'd22;
      5'd6:  t = 5'd17;
      5'd7:  t = 5'd11;
      5'd8:  t = 5'd5;
      5'd9:  t = 5'd1;
      5'd10: t = 5'd3;
      5'd11: t = 5'd10;
      5'd12: t = 5'd14;
      5'd13: t = 5'd19;
      5'd14: t = 5'd24;
      5'd15: t = 5'd20;
      5'd16: t = 5'd16;
      5'd17: t = 5'd6;
      5'd18: t = 5'd4;
      5'd19: t = 5'd13;
      5'd20: t = 5'd7;
      5'd21: t = 5'd23;
      5'd22: t = 5'd12;
      5'd23: t = 5'd8;
      5'd24: t = 5'd21;
      5'd25: t = 5'd18;
      default: t = 5'd0;
    endcase
    return t;
  endfunction

  // Inverse of rotor III "BDFHJLCPRTXVZNYEIWGAKMUSQO"
  function automatic logic [4:0] inv_r2(input logic [4:0] idx);
    logic [4:0] t;
    t = 5'd0;
    case (idx)
      5'd0:  t = 5'd19;
      5'd1:  t = 5'd0;
      5'd2:  t = 5'd6;
      5'd3:  t = 5'd1;
      5'd4:  t = 5'd15;
      5'd5:  t = 5'd2;
      5'd6:  t = 5'd18;
      5'd7:  t = 5'd3;
      5'd8:  t = 5'd16;
      5'd9:  t = 5'd4;
      5'd10: t = 5'd20;
      5'd11: t = 5'd5;
      5'd12: t = 5'd21;
      5'd13: t = 5'd13;
      5'd14: t = 5'd25;
      5'd15: t = 5'd7;
      5'd16: t = 5'd24;
      5'd17: t = 5'd8;
      5'd18: t = 5'd23;
      5'd19: t = 5'd9;
      5'd20: t = 5'd22;
      5'd21: t = 5'd11;
      5'd22: t = 5'd17;
      5'd23: t = 5'd10;
      5'd24: t = 5'd14;
      5'd25: t = 5'd12;
      default: t = 5'd0;
    endcase
    return t;
  endfunction

  // (Winv[(in + p) mod 26] - p) mod 26; out-of-range codes give don't-care results
  // because err is already set for them.
  function automatic logic [4:0] inv_step(input logic [1:0] rotor,
                                          input logic [4:0] in,
                                          input logic [4:0] p);
    logic [5:0] idx;
    logic [5:0] w;
    logic [5:0] res;
    idx = {1'b0, in} + {1'b0, p};
    if (idx >= 6'd26) idx = idx - 6'd26;
    case (rotor)
      2'd0:    w = {1'b0, inv_r0(idx[4:0])};
      2'd1:    w = {1'b0, inv_r1(idx[4:0])};
      default: w = {1'b0, inv_r2(idx[4:0])};
    endcase
    res = w + 6'd26 - {1'b0, p};
    if (res >= 6'd26) res = res - 6'd26;
    return res[4:0];
  endfunction

  logic       v1, v2, v3;
  logic [4:0] d1, d2, d3;
  logic       e1, e2, e3;
  logic [4:0] r1_s1, r2_s1, r1_s2;
  logic       ld1, ld2, ld3;
  logic       bad_in;
  logic [4:0] m1, m2, m3;

  always_comb begin
    ld3      = !v3 || out_ready;
    ld2      = !v2 || ld3;
    ld1      = !v1 || ld2;
    in_ready = ld1;
    bad_in   = (data_in > 5'd25) || (r1_pos > 5'd25) ||
               (r2_pos > 5'd25) || (r3_pos > 5'd25);
    m1       = inv_step(2'd2, data_in, r3_pos);
    m2       = inv_step(2'd1, d1, r2_s1);
    m3       = inv_step(2'd0, d2, r1_s2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      d1    <= 5'd0;
      d2    <= 5'd0;
      d3    <= 5'd0;
      e1    <= 1'b0;
      e2    <= 1'b0;
      e3    <= 1'b0;
      r1_s1 <= 5'd0;
      r2_s1 <= 5'd0;
      r1_s2 <= 5'd0;
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid) begin
          d1    <= m1;
          e1    <= bad_in;
          r1_s1 <= r1_pos;
          r2_s1 <= r2_pos;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          d2    <= m2;
          e2    <= e1;
          r1_s2 <= r1_s1;
        end
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) begin
          d3 <= e2 ? 5'd31 : m3;
          e3 <= e2;
        end
      end
    end
  end

  assign out_valid = v3;
  assign data_out  = d3;
  assign err       = e3;

endmodule
